// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweep controller: walks every input vector of an external
// combinational gate, samples its output after a settle time and grades it.
module gate_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 gate_y,
  output logic [N_IN-1:0]      gate_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int NV = 2**N_IN;
  localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NV-1:0]     table_q, table_d;
  logic              pass_q, pass_d;
  logic [N_IN-1:0]   fail_q, fail_d;
  logic [NV-1:0]     table_smp;

  // Lowest set bit of the mismatch vector; 0 when there is no mismatch.
  function automatic logic [N_IN-1:0] first_mismatch(input logic [NV-1:0] diff);
    logic [N_IN-1:0] r;
    r = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (diff[i]) r = i[N_IN-1:0];
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    table_d   = table_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    table_smp = table_q;
    table_smp[idx_q] = gate_y;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          table_d = '0;
          pass_d  = 1'b0;
          fail_d  = '0;
        end
      end
      DRIVE: begin
        if (abort) begin
          // Partial captures are kept for debug; only the verdict is cleared.
          state_d = IDLE;
          pass_d  = 1'b0;
          fail_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          table_d = table_smp;
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + 1'b1;
          end else begin
            // Grade against the table including the bit sampled this edge.
            state_d = DONE;
            pass_d  = (table_smp == expected);
            fail_d  = first_mismatch(table_smp ^ expected);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign gate_in   = (state_q == DRIVE) ? idx_q : '0;
  assign busy      = (state_q == DRIVE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign table_out = table_q;
  assign fail_idx  = fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl with a scoreboard of sweep verdicts;
// a second instance runs with SETTLE=1 for back-to-back sweeps.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, start1, abort1;
  logic [3:0] exp_r;
  logic       gate_y, gate_y1;
  logic [1:0] gate_in, gate_in1;
  logic       busy, done, pass, busy1, done1, pass1;
  logic [3:0] table_out, table_out1;
  logic [1:0] fail_idx, fail_idx1;
  bit         fault;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       p;
    logic [3:0] t;
    logic [1:0] f;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Gate under test: AND of a (bit 0) and b (bit 1), or OR when faulty.
  assign gate_y  = fault ? (gate_in[0]  | gate_in[1])  : (gate_in[0]  & gate_in[1]);
  assign gate_y1 = fault ? (gate_in1[0] | gate_in1[1]) : (gate_in1[0] & gate_in1[1]);

  gate_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(exp_r),
    .gate_y(gate_y), .gate_in(gate_in), .busy(busy), .done(done), .pass(pass),
    .table_out(table_out), .fail_idx(fail_idx)
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp_r),
    .gate_y(gate_y1), .gate_in(gate_in1), .busy(busy1), .done(done1), .pass(pass1),
    .table_out(table_out1), .fail_idx(fail_idx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      logic a, b;
      a = i[0];
      b = i[1];
      e.t[i] = fault ? (a | b) : (a & b);
    end
    e.p = (e.t == exp_r);
    e.f = 2'd0;
    for (int i = 3; i >= 0; i--) if (e.t[i] != exp_r[i]) e.f = i[1:0];
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag, input logic p, input logic [3:0] t,
                          input logic [1:0] f);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_pass"}, p, e.p);
      check({tag, "_table"}, t, e.t);
      check({tag, "_fidx"}, f, e.f);
    end
  endtask

  // Full default sweep; optional start re-pulses and an abort during DONE.
  task automatic sweep(input string tag, input bit rep, input bit ab_done);
    int done_cnt, done_at;
    done_cnt = 0;
    done_at  = 0;
    sb_push();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) begin
        check({tag, "_gate_in"}, gate_in, (k - 1) / 2);
        check({tag, "_busy"}, busy, 1'b1);
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        check({tag, "_gate_in_done"}, gate_in, 2'd0);
        check({tag, "_busy_done"}, busy, 1'b0);
        sb_check(tag, pass, table_out, fail_idx);
        if (ab_done) abort = 1'b1;
      end
      if (rep && (k == 3 || k == 8)) start = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_at"}, done_at, 9);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  // Abort issued during the 5th DRIVE cycle.
  task automatic abort_test(input string tag, input logic [3:0] tbl);
    int done_cnt;
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_fidx"}, fail_idx, 2'd0);
    check({tag, "_table"}, table_out, tbl);
    check({tag, "_gate_in"}, gate_in, 2'd0);
    for (int k = 0; k < 10; k++) begin
      if (done) done_cnt++;
      step();
    end
    check({tag, "_no_done"}, done_cnt, 0);
  endtask

  // SETTLE=1 sweep, returning cycles from the start edge to done.
  task automatic sweep1(input string tag, output int at);
    at = 0;
    sb_push();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (done1) begin
        at = k;
        sb_check(tag, pass1, table_out1, fail_idx1);
        step();
        break;
      end
      step();
    end
    check({tag, "_done_at"}, at, 5);
  endtask

  initial begin
    int at;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    exp_r  = 4'b1000;
    fault  = 1'b0;
    step();
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_table", table_out, 4'd0);
    check("rst_fidx", fail_idx, 2'd0);
    check("rst_gate_in", gate_in, 2'd0);
    rst_n = 1'b1;
    step();

    sweep("and", 1'b0, 1'b0);
    check("hold_pass", pass, 1'b1);
    check("hold_table", table_out, 4'b1000);

    sweep("restart", 1'b1, 1'b0);

    fault = 1'b1;
    sweep("or", 1'b0, 1'b0);

    // start and abort together in IDLE: abort wins, results untouched.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("both_busy", busy, 1'b0);
    check("both_table", table_out, 4'b1110);
    check("both_fidx", fail_idx, 2'd1);

    fault = 1'b0;
    sweep("ab_done", 1'b0, 1'b1);
    check("ab_done_pass", pass, 1'b1);

    abort_test("abort_and", 4'b0000);
    fault = 1'b1;
    abort_test("abort_or", 4'b0010);

    // Reset asserted in the 4th DRIVE cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_pass", pass, 1'b0);
    check("mid_rst_table", table_out, 4'd0);
    check("mid_rst_fidx", fail_idx, 2'd0);
    check("mid_rst_gate_in", gate_in, 2'd0);
    for (int k = 0; k < 8; k++) begin
      if (done) check("mid_rst_no_done", done, 1'b0);
      step();
    end
    fault = 1'b0;
    sweep("after_rst", 1'b0, 1'b0);

    sweep1("s1_a", at);
    sweep1("s1_b", at);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
